pe_sum_scheduler: RTL and testbench

- Job-level controller for a group of three PE units whose partial results are summed into one output value per output pixel.
- For each pixel it issues a start pulse to all three PEs and collects their done/data returns in any order, including simultaneous returns.
- It accumulates the three partials and presents the sum on a valid/ready output port.
- It repeats this for num_pix pixels per job and flags job completion. It sits between the layer-level control FSM and the PE array.

---
 rtl/pe_sum_scheduler.sv | 132 +++++++++++++
 tb/tb_pe_sum_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_sum_scheduler.sv
// Per-pixel job controller for a group of three PEs: it issues a start to all lanes,
// sums their partial results as they return in any order, and hands the sum downstream.
module pe_sum_scheduler #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_pix,
  output logic              busy,
  output logic [2:0]        pe_start,
  input  logic [2:0]        pe_done,
  input  logic [DATA_W-1:0] pe_data_0,
  input  logic [DATA_W-1:0] pe_data_1,
  input  logic [DATA_W-1:0] pe_data_2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  pix_idx,
  output logic              job_done
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCollect,
    StOutput,
    StFinish
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    num_pix_q, num_pix_d;
  logic [CNT_W-1:0]    pix_idx_q, pix_idx_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [2:0]          got_q, got_d;

  logic [2:0]          lane_new;
  logic [2:0]          got_all;
  logic [DATA_W-1:0]   add_0, add_1, add_2;
  logic [DATA_W-1:0]   lane_sum;
  logic [CNT_W-1:0]    last_idx;

  // Only lanes not yet collected for this pixel contribute; repeat strobes fall away here.
  assign lane_new = pe_done & ~got_q;
  assign got_all  = got_q | lane_new;
  assign add_0    = lane_new[0] ? pe_data_0 : '0;
  assign add_1    = lane_new[1] ? pe_data_1 : '0;
  assign add_2    = lane_new[2] ? pe_data_2 : '0;
  assign lane_sum = acc_q + add_0 + add_1 + add_2;
  assign last_idx = num_pix_q - CNT_W'(1);

  always_comb begin
    state_d    = state_q;
    num_pix_d  = num_pix_q;
    pix_idx_d  = pix_idx_q;
    acc_d      = acc_q;
    got_d      = got_q;
    out_data_d = out_data_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (num_pix != '0) begin
            num_pix_d = num_pix;
            pix_idx_d = '0;
            state_d   = StIssue;
          end else begin
            state_d = StFinish;
          end
        end
      end
      StIssue: begin
        acc_d   = '0;
        got_d   = '0;
        state_d = StCollect;
      end
      StCollect: begin
        acc_d = lane_sum;
        got_d = got_all;
        if (got_all == 3'b111) begin
          out_data_d = lane_sum;
          state_d    = StOutput;
        end
      end
      StOutput: begin
        if (out_ready) begin
          if (pix_idx_q == last_idx) begin
            state_d = StFinish;
          end else begin
            pix_idx_d = pix_idx_q + CNT_W'(1);
            state_d   = StIssue;
          end
        end
      end
      StFinish: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      num_pix_q  <= '0;
      pix_idx_q  <= '0;
      acc_q      <= '0;
      got_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      num_pix_q  <= num_pix_d;
      pix_idx_q  <= pix_idx_d;
      acc_q      <= acc_d;
      got_q      <= got_d;
      out_data_q <= out_data_d;
    end
  end

  // Every output is a decode of registered state, so no input reaches an output in-cycle.
  assign busy      = (state_q != StIdle);
  assign pe_start  = {3{state_q == StIssue}};
  assign out_valid = (state_q == StOutput);
  assign job_done  = (state_q == StFinish);
  assign out_data  = out_data_q;
  assign pix_idx   = pix_idx_q;

endmodule

// File: tb/tb_pe_sum_scheduler.sv
// Directed, table-driven bench for pe_sum_scheduler: per-pixel return patterns from a vector
// table, plus hand-written backpressure, empty-job, ignored-start and mid-job-reset sequences.
module tb_pe_sum_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  num_pix;
  logic        busy;
  logic [2:0]  pe_start;
  logic [2:0]  pe_done;
  logic [15:0] pe_data_0, pe_data_1, pe_data_2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [7:0]  pix_idx;
  logic        job_done;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_xfer = 0;
  int n_done = 0;
  int n_issue = 0;

  pe_sum_scheduler #(.DATA_W(16), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_pix   (num_pix),
    .busy      (busy),
    .pe_start  (pe_start),
    .pe_done   (pe_done),
    .pe_data_0 (pe_data_0),
    .pe_data_1 (pe_data_1),
    .pe_data_2 (pe_data_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .pix_idx   (pix_idx),
    .job_done  (job_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset) begin
      if (out_valid && out_ready) n_xfer <= n_xfer + 1;
      if (job_done) n_done <= n_done + 1;
      if (pe_start != 3'b000) n_issue <= n_issue + 1;
    end
  end

  // One record per pixel: up to four COLLECT-cycle done patterns with data, and the sum.
  typedef struct packed {
    logic [2:0]        n;
    logic [3:0][2:0]   done;
    logic [3:0][15:0]  d0;
    logic [3:0][15:0]  d1;
    logic [3:0][15:0]  d2;
    logic [15:0]       exp;
  } vec_t;

  localparam int NVEC = 5;
  vec_t vecs [NVEC];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_job(input logic [7:0] n);
    start   = 1'b1;
    num_pix = n;
    tick();
    start   = 1'b0;
    num_pix = 8'd0;
  endtask

  // Entered at the ISSUE cycle; leaves right after the output transfer edge.
  task automatic do_pixel(input int v, input int hold, input logic [7:0] exp_idx);
    check("pe_start_issue", {29'd0, pe_start}, 32'h7);
    check("pix_idx", {24'd0, pix_idx}, {24'd0, exp_idx});
    pe_done = 3'b000;
    tick();
    for (int k = 0; k < int'(vecs[v].n); k++) begin
      check("out_valid_collect", {31'd0, out_valid}, 32'd0);
      pe_done   = vecs[v].done[k];
      pe_data_0 = vecs[v].done[k][0] ? vecs[v].d0[k] : 16'hDEAD;
      pe_data_1 = vecs[v].done[k][1] ? vecs[v].d1[k] : 16'hDEAD;
      pe_data_2 = vecs[v].done[k][2] ? vecs[v].d2[k] : 16'hDEAD;
      tick();
    end
    pe_done   = 3'b000;
    pe_data_0 = 16'h0;
    pe_data_1 = 16'h0;
    pe_data_2 = 16'h0;
    check("out_valid", {31'd0, out_valid}, 32'd1);
    check("out_data", {16'd0, out_data}, {16'd0, vecs[v].exp});
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_data", {16'd0, out_data}, {16'd0, vecs[v].exp});
      check("hold_no_issue", {29'd0, pe_start}, 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base_x, base_d, base_i;

    for (int i = 0; i < NVEC; i++) vecs[i] = '0;
    // Simultaneous returns
    vecs[0].n = 3'd1; vecs[0].done[0] = 3'b111;
    vecs[0].d0[0] = 16'h0010; vecs[0].d1[0] = 16'h0020; vecs[0].d2[0] = 16'h0030;
    vecs[0].exp = 16'h0060;
    // Out of order with a repeated PE2 strobe
    vecs[1].n = 3'd4;
    vecs[1].done[0] = 3'b100; vecs[1].d2[0] = 16'h0005;
    vecs[1].done[1] = 3'b001; vecs[1].d0[1] = 16'h0100;
    vecs[1].done[2] = 3'b100; vecs[1].d2[2] = 16'hFFFF;
    vecs[1].done[3] = 3'b010; vecs[1].d1[3] = 16'h0002;
    vecs[1].exp = 16'h0107;
    // Modulo wrap
    vecs[2].n = 3'd2;
    vecs[2].done[0] = 3'b011; vecs[2].d0[0] = 16'hFFFF; vecs[2].d1[0] = 16'h0001;
    vecs[2].done[1] = 3'b100; vecs[2].d2[1] = 16'h0003;
    vecs[2].exp = 16'h0003;
    vecs[3].n = 3'd1; vecs[3].done[0] = 3'b111;
    vecs[3].d0[0] = 16'h0001; vecs[3].d1[0] = 16'h0002; vecs[3].d2[0] = 16'h0003;
    vecs[3].exp = 16'h0006;
    // Idle cycle, then overlapping strobes where PE2 repeats alongside PE1
    vecs[4].n = 3'd3;
    vecs[4].done[0] = 3'b000;
    vecs[4].done[1] = 3'b101; vecs[4].d0[1] = 16'h1234; vecs[4].d2[1] = 16'h0100;
    vecs[4].done[2] = 3'b110; vecs[4].d1[2] = 16'h0001; vecs[4].d2[2] = 16'hBEEF;
    vecs[4].exp = 16'h1335;

    reset = 1'b1; start = 1'b0; num_pix = 8'd0; pe_done = 3'b000;
    pe_data_0 = 16'h0; pe_data_1 = 16'h0; pe_data_2 = 16'h0; out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pe_start", {29'd0, pe_start}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {16'd0, out_data}, 32'd0);
    check("rst_pix_idx", {24'd0, pix_idx}, 32'd0);
    check("rst_job_done", {31'd0, job_done}, 32'd0);

    // Single-pixel jobs from the table
    for (int v = 0; v < NVEC; v++) begin
      start_job(8'd1);
      check("busy_issue", {31'd0, busy}, 32'd1);
      do_pixel(v, 0, 8'd0);
      check("job_done", {31'd0, job_done}, 32'd1);
      tick();
      check("job_done_single", {31'd0, job_done}, 32'd0);
      check("busy_after", {31'd0, busy}, 32'd0);
    end

    // Backpressure on pixel 1 of a three-pixel job
    base_x = n_xfer; base_d = n_done; base_i = n_issue;
    start_job(8'd3);
    do_pixel(0, 0, 8'd0);
    do_pixel(1, 5, 8'd1);
    do_pixel(2, 0, 8'd2);
    check("bp_job_done", {31'd0, job_done}, 32'd1);
    tick();
    tick();
    check("bp_xfers", n_xfer - base_x, 32'd3);
    check("bp_done_count", n_done - base_d, 32'd1);
    check("bp_issue_count", n_issue - base_i, 32'd3);

    // Empty job
    base_x = n_xfer; base_d = n_done; base_i = n_issue;
    start_job(8'd0);
    check("empty_job_done", {31'd0, job_done}, 32'd1);
    check("empty_pe_start", {29'd0, pe_start}, 32'd0);
    check("empty_out_valid", {31'd0, out_valid}, 32'd0);
    tick();
    check("empty_idle", {31'd0, busy}, 32'd0);
    check("empty_issue_count", n_issue - base_i, 32'd0);
    check("empty_xfer_count", n_xfer - base_x, 32'd0);
    check("empty_done_count", n_done - base_d, 32'd1);

    // Start held high through a busy two-pixel job, including its FINISH cycle
    start_job(8'd2);
    start = 1'b1; num_pix = 8'd0;
    do_pixel(0, 0, 8'd0);
    do_pixel(3, 0, 8'd1);
    check("busy_start_finish", {31'd0, job_done}, 32'd1);
    tick();
    check("busy_start_idle", {31'd0, busy}, 32'd0);
    check("busy_start_pix", {24'd0, pix_idx}, 32'd1);
    start = 1'b0;
    tick();
    check("busy_start_stays_idle", {31'd0, busy}, 32'd0);

    // Reset during COLLECT of pixel 1 with two lanes collected
    start_job(8'd2);
    do_pixel(0, 0, 8'd0);
    check("abort_pix1", {24'd0, pix_idx}, 32'd1);
    pe_done = 3'b000;
    tick();
    pe_done = 3'b011; pe_data_0 = 16'h0100; pe_data_1 = 16'h0200;
    tick();
    pe_done = 3'b000; pe_data_0 = 16'h0; pe_data_1 = 16'h0;
    base_d = n_done;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_pe_start", {29'd0, pe_start}, 32'd0);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_data", {16'd0, out_data}, 32'd0);
    check("abort_pix_idx", {24'd0, pix_idx}, 32'd0);
    check("abort_job_done", {31'd0, job_done}, 32'd0);
    tick();
    tick();
    check("abort_no_done", n_done - base_d, 32'd0);
    start_job(8'd1);
    do_pixel(3, 0, 8'd0);
    check("post_abort_done", {31'd0, job_done}, 32'd1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
